// File: rtl/real_capture_pkg.sv
// Shared types and elaboration helpers for the real_capture sample buffer.
package real_capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ARMED,
    POST,
    READ
  } state_t;

  // Pointer width for a DEPTH-entry circular buffer.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 4) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit pre_ok(input int depth, input int pre);
    return (pre >= 1) && (pre < depth);
  endfunction

endpackage

// File: rtl/real_capture_mem.sv
// Simple dual-port sample RAM: one write port, one registered read port.
module real_capture_mem #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: no reset on the array or its read register, so this maps onto block RAM;
  // the captured samples deliberately survive a reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/real_capture.sv
// Pre/post-trigger capture buffer for fixed-point model outputs with handshaked readback.
// Optional sample decimation is enabled by defining REAL_CAPTURE_DECIM_EN (adds the decim port).
module real_capture
  import real_capture_pkg::*;
#(
  parameter int WIDTH    = 25,
  parameter int EXPONENT = -16,
  parameter int DEPTH    = 64,
  parameter int PRE      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_,
  input  logic             arm,
  input  logic             trig,
`ifdef REAL_CAPTURE_DECIM_EN
  input  logic [7:0]       decim,
`endif
  output logic             busy,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             rd_last,
  output logic             done
);

  localparam int PW     = clog2(DEPTH);
  localparam int POST_N = DEPTH - PRE;

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("real_capture: DEPTH=%0d must be a power of two >= 4", DEPTH);
  end
  if (!pre_ok(DEPTH, PRE)) begin : g_bad_pre
    $error("real_capture: PRE=%0d must satisfy 1 <= PRE < DEPTH=%0d (EXPONENT=%0d)",
           PRE, DEPTH, EXPONENT);
  end

  state_t           state, state_next;
  logic [PW-1:0]    wr_ptr, rd_ptr, start_ptr, trig_start;
  logic [PW-1:0]    cnt, rd_cnt;
  logic             se, wr_en, rd_en;
  logic [WIDTH-1:0] q;

`ifdef REAL_CAPTURE_DECIM_EN
  logic [7:0] dec_cnt;

  // Held at zero in IDLE so the first FILL cycle is always a sample cycle.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) dec_cnt <= '0;
    else if (dec_cnt == decim) dec_cnt <= '0;
    else                       dec_cnt <= dec_cnt + 8'd1;
  end

  assign se = (dec_cnt == 8'd0);
`else
  assign se = 1'b1;
`endif

  assign trig_start = wr_ptr - PW'(PRE);
  assign busy       = (state != IDLE);
  assign rd_last    = rd_valid && (rd_cnt == PW'(DEPTH - 1));
  // The RAM output register is never reset, so gate it to read zero when idle.
  assign rd_data    = rd_valid ? q : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    case (state)
      IDLE:  if (arm) state_next = FILL;
      FILL:  if (se) begin
               wr_en = 1'b1;
               if (cnt == PW'(PRE - 1)) state_next = ARMED;
             end
      ARMED: if (se) begin
               wr_en = 1'b1;
               if (trig) state_next = (POST_N == 1) ? READ : POST;
             end
      POST:  if (se) begin
               wr_en = 1'b1;
               if (cnt == PW'(POST_N - 1)) state_next = READ;
             end
      READ:  begin
               if (!rd_valid) rd_en = 1'b1;
               else if (rd_ready) begin
                 if (rd_last) state_next = IDLE;
                 else         rd_en      = 1'b1;
               end
             end
      default: state_next = IDLE;
    endcase
  end

  // rd_ptr is the fetch address: it runs one sample ahead of the one on rd_data.
  // NOTE: registered state uses non-blocking assignments so every process sees the
  // pre-edge values; later assignments in the same edge override earlier ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      start_ptr <= '0;
      cnt       <= '0;
      rd_cnt    <= '0;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      case (state)
        IDLE: if (arm) begin
          wr_ptr <= '0;
          cnt    <= '0;
          rd_cnt <= '0;
        end
        FILL: if (wr_en) cnt <= (state_next == ARMED) ? '0 : cnt + PW'(1);
        ARMED: if (wr_en && trig) begin
          start_ptr <= trig_start;
          rd_ptr    <= trig_start;
          cnt       <= PW'(1);
        end
        POST: if (wr_en) begin
          cnt <= cnt + PW'(1);
          if (state_next == READ) rd_ptr <= start_ptr;
        end
        READ: begin
          if (!rd_valid) rd_valid <= 1'b1;
          else if (rd_ready) begin
            if (rd_last) begin
              rd_valid <= 1'b0;
              done     <= 1'b1;
            end else begin
              rd_cnt <= rd_cnt + PW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  real_capture_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (in_),
    .re    (rd_en),
    .raddr (rd_ptr),
    .rdata (q)
  );

endmodule

// File: doc/real_capture.md
REAL_CAPTURE -- requirements
Module: real_capture

Interface
REQ-001 The block SHALL have these parameters:
- WIDTH, 25: signed fixed-point sample width (svreal format).
- EXPONENT, -16: fixed-point exponent; metadata only, never used in arithmetic.
- DEPTH, 64: capture buffer entries; power of two, >= 4.
- PRE, 16: pre-trigger samples; 1 <= PRE < DEPTH.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  emulator clock.
- rst  in  1  reset; synchronous, active-high.
- in_  in  WIDTH  fixed-point sample from the model output.
- arm  in  1  start-capture request.
- trig  in  1  trigger qualifier.
- busy  out  1  high in every state except IDLE.
- rd_data  out  WIDTH  readback sample.
- rd_valid  out  1  rd_data is valid.
- rd_ready  in  1  consumer accepts rd_data.
- rd_last  out  1  marks the final readback sample.
- done  out  1  one-cycle pulse after the last sample is read.

Function
REQ-003 The FSM SHALL have five states: IDLE, FILL, ARMED, POST and READ.
REQ-004 A sample-enable (se) SHALL be high every cycle (see Configuration); all buffer writes SHALL occur only on se cycles.
REQ-005 In IDLE, arm=1 SHALL clear wr_ptr and the sample count and move to FILL on the next cycle; trig SHALL be ignored, including when it coincides with arm.
REQ-006 In FILL, each se cycle SHALL write in_ to mem[wr_ptr] and increment wr_ptr modulo DEPTH; after PRE writes the FSM SHALL move to ARMED; trig SHALL be ignored.
REQ-007 In ARMED, writes SHALL continue circularly; the first se cycle with trig=1 SHALL:
- write that sample as post-sample 1;
- latch start_ptr = (wr_ptr - PRE) mod DEPTH;
- move to POST.
REQ-008 In POST, writes SHALL continue until DEPTH-PRE post-samples in total have been written, then the FSM SHALL move to READ; trig SHALL be ignored.
REQ-009 In READ, reading SHALL start at start_ptr, giving chronological order: PRE pre-trigger samples, then the trigger sample, then the remaining post-samples.
REQ-010 In READ, rd_valid SHALL rise one cycle after READ is entered, because memory read latency is 1 cycle.
REQ-011 rd_data SHALL hold stable while rd_valid=1 and rd_ready=0.
REQ-012 Each rd_valid & rd_ready handshake SHALL advance rd_ptr modulo DEPTH; back-to-back handshakes SHALL sustain one sample per cycle.
REQ-013 rd_last SHALL be high with the DEPTH-th sample only.
REQ-014 After the last handshake, the FSM SHALL return to IDLE, drop rd_valid and pulse done for exactly one cycle.
REQ-015 arm SHALL be ignored in every state except IDLE.
REQ-016 Samples SHALL be stored bit-exact with no scaling, rounding or saturation.

Reset
REQ-017 rst=1 at a clock edge SHALL force the following, from any state including mid-capture or mid-readback:
- state = IDLE;
- wr_ptr, rd_ptr, start_ptr and counters = 0;
- busy, rd_valid, rd_last, done and rd_data = 0.
REQ-018 Reset SHALL NOT clear the buffer contents.

Configuration
REQ-019 With REAL_CAPTURE_DECIM_EN defined, the block SHALL add an input port decim (8 bits), and se SHALL be high once every decim+1 cycles.
REQ-020 The decimation counter SHALL restart on the arm acceptance cycle, so that the first se occurs on the first FILL cycle.
REQ-021 Without REAL_CAPTURE_DECIM_EN, the decim port SHALL be absent and se SHALL be constant 1.

Structure
REQ-022 Package real_capture_pkg SHALL hold:
- the state enum;
- the pointer-width function clog2(DEPTH);
- the elaboration checks on DEPTH and PRE.
REQ-023 Sub-module real_capture_mem SHALL be a simple dual-port RAM with one write port, one registered-read port and no reset.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- DEPTH=8, PRE=3, in_ = cycle index; arm at t=0; trig at sample 10 -> readback 7,8,9,10,11,12,13,14; rd_last on 14; done pulses once.
- trig held high during FILL -> ignored; the first trig seen in ARMED is captured and the readback holds exactly PRE pre-samples.
- rd_ready toggling 1,0,0,1 -> rd_data is stable across stalls; no sample is lost or duplicated.
- rst asserted in POST, then a second arm and trig -> clean capture; busy=0 and rd_valid=0 during reset.
- arm and trig both asserted in IDLE -> FILL entered; trig ignored; arm during READ is ignored.
- With REAL_CAPTURE_DECIM_EN and decim=2 -> stored samples are every third cycle's in_; readback order is still correct.
